// File: rtl/mining_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mining_pkg                                                           |
// | Process codes shared with memory_control and the sequencer states.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mining_pkg;

  localparam logic [2:0] PROC_IDLE  = 3'b000;
  localparam logic [2:0] PROC_INIT  = 3'b001;
  localparam logic [2:0] PROC_LOAD  = 3'b010;
  localparam logic [2:0] PROC_HASH  = 3'b011;
  localparam logic [2:0] PROC_STORE = 3'b100;
  localparam logic [2:0] PROC_DONE  = 3'b101;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_INIT     = 4'd1,
    S_INIT_REL = 4'd2,
    S_LOAD     = 4'd3,
    S_HASH     = 4'd4,
    S_STORE    = 4'd5,
    S_DONE     = 4'd6,
    S_ERROR    = 4'd7
  } state_t;

  function automatic logic [2:0] proc_code(input state_t s);
    logic [2:0] code;
    code = PROC_IDLE;
    case (s)
      S_INIT, S_INIT_REL: code = PROC_INIT;
      S_LOAD:             code = PROC_LOAD;
      S_HASH:             code = PROC_HASH;
      S_STORE:            code = PROC_STORE;
      S_DONE:             code = PROC_DONE;
      default:            code = PROC_IDLE;
    endcase
    return code;
  endfunction

  function automatic logic is_busy_state(input state_t s);
    return (s != S_IDLE) && (s != S_ERROR);
  endfunction

  // States in which the memory controller owes a response and may time out.
  function automatic logic is_timed_state(input state_t s);
    return (s == S_INIT) || (s == S_INIT_REL) || (s == S_LOAD) ||
           (s == S_HASH) || (s == S_STORE);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mining_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mining_sequencer_if                                                  |
// | Run control, status and memory_control handshake of the sequencer.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface mining_sequencer_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] run_blocks;
  logic             abort;
  logic             finished_init;
  logic             done_memory_store;
  logic             done_hash_store;
  logic             init_memory;
  logic             load_memory;
  logic [2:0]       process;
  logic             busy;
  logic             block_done;
  logic [CNT_W-1:0] block_count;
  logic             timeout_err;

  modport master (
    input  start, run_blocks, abort,
    input  finished_init, done_memory_store, done_hash_store,
    output init_memory, load_memory, process,
    output busy, block_done, block_count, timeout_err
  );

  modport slave (
    output start, run_blocks, abort,
    output finished_init, done_memory_store, done_hash_store,
    input  init_memory, load_memory, process,
    input  busy, block_done, block_count, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_timer                                                          |
// | Up-counter with clear/load that holds at, and flags, TERMINAL.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_timer #(
  parameter int WIDTH    = 12,
  parameter int TERMINAL = 4095
) (
  input  wire logic             clock,
  input  wire logic             reset,
  input  wire logic             clear,
  input  wire logic             load,
  input  wire logic [WIDTH-1:0] load_value,
  input  wire logic             enable,
  output logic                  tc
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc = (count_q == WIDTH'(TERMINAL));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_value;
    end else if (enable && !tc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mining_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mining_sequencer                                                     |
// | Steps memory_control through INIT then LOAD/HASH/STORE per block.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module mining_sequencer
  import mining_pkg::*;
#(
  parameter int LOAD_SETTLE = 20,
  parameter int TIMEOUT     = 4095,
  parameter int CNT_W       = 8
) (
  input  wire logic          clock,
  input  wire logic          reset,
  mining_sequencer_if.master bus
);

  localparam int SETTLE_W = $clog2(LOAD_SETTLE + 1);
  localparam int TMO_W    = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic             sub_q, sub_d;
  logic             abort_q, abort_d;
  logic [CNT_W-1:0] target_q, target_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             init_memory_q, init_memory_d;
  logic             load_memory_q, load_memory_d;
  logic [2:0]       process_q, process_d;
  logic             busy_q, busy_d;
  logic             block_done_q, block_done_d;
  logic             timeout_err_q, timeout_err_d;

  logic             settle_tc;
  logic             timeout_tc;
  logic             load_ack;
  logic             state_change;

  // sub_q marks the second half of a two-step phase: load acked in S_LOAD,
  // hash released in S_STORE.
  assign load_ack     = (state_q == S_LOAD) && !sub_q && !bus.done_memory_store;
  assign state_change = (state_d != state_q);

  phase_timer #(
    .WIDTH    (SETTLE_W),
    .TERMINAL (LOAD_SETTLE)
  ) u_settle_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_q != S_LOAD),
    .load       (load_ack),
    .load_value (SETTLE_W'(1)),
    .enable     ((state_q == S_LOAD) && sub_q),
    .tc         (settle_tc)
  );

  phase_timer #(
    .WIDTH    (TMO_W),
    .TERMINAL (TIMEOUT)
  ) u_timeout_timer (
    .clock      (clock),
    .reset      (reset),
    .clear      (state_change),
    .load       (1'b0),
    .load_value ({TMO_W{1'b0}}),
    .enable     (1'b1),
    .tc         (timeout_tc)
  );

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    abort_d  = abort_q;
    target_d = target_q;
    count_d  = count_q;

    if (is_busy_state(state_q) && bus.abort) begin
      abort_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          target_d = (bus.run_blocks == '0) ? CNT_W'(1) : bus.run_blocks;
          count_d  = '0;
          state_d  = S_INIT;
        end
      end
      S_INIT: begin
        if (bus.finished_init) begin
          state_d = S_INIT_REL;
        end
      end
      S_INIT_REL: begin
        if (!bus.finished_init && bus.done_memory_store) begin
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!sub_q) begin
          if (!bus.done_memory_store) begin
            sub_d = 1'b1;
          end
        end else if (settle_tc) begin
          state_d = S_HASH;
        end
      end
      S_HASH: begin
        if (bus.done_hash_store) begin
          state_d = S_STORE;
        end
      end
      S_STORE: begin
        if (!sub_q) begin
          if (!bus.done_hash_store) begin
            sub_d = 1'b1;
          end
        end else if (bus.done_memory_store) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        count_d = (count_q == {CNT_W{1'b1}}) ? count_q : count_q + 1'b1;
        state_d = ((count_d == target_q) || abort_q) ? S_IDLE : S_LOAD;
      end
      S_ERROR: begin
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // A real phase transition in the same cycle wins over the timeout.
    if (is_timed_state(state_q) && (state_d == state_q) && timeout_tc) begin
      state_d = S_ERROR;
    end

    if (state_d != state_q) begin
      sub_d = 1'b0;
      if (state_d == S_IDLE) begin
        abort_d = 1'b0;
      end
    end
  end

  always_comb begin
    process_d     = proc_code(state_q);
    init_memory_d = (state_q == S_INIT);
    load_memory_d = (state_q == S_LOAD) && !sub_q;
    busy_d        = is_busy_state(state_q);
    block_done_d  = (state_q == S_DONE);
    timeout_err_d = timeout_err_q | (state_q == S_ERROR);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sub_q         <= 1'b0;
      abort_q       <= 1'b0;
      target_q      <= '0;
      count_q       <= '0;
      init_memory_q <= 1'b0;
      load_memory_q <= 1'b0;
      process_q     <= PROC_IDLE;
      busy_q        <= 1'b0;
      block_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sub_q         <= sub_d;
      abort_q       <= abort_d;
      target_q      <= target_d;
      count_q       <= count_d;
      init_memory_q <= init_memory_d;
      load_memory_q <= load_memory_d;
      process_q     <= process_d;
      busy_q        <= busy_d;
      block_done_q  <= block_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.init_memory = init_memory_q;
  assign bus.load_memory = load_memory_q;
  assign bus.process     = process_q;
  assign bus.busy        = busy_q;
  assign bus.block_done  = block_done_q;
  assign bus.block_count = count_q;
  assign bus.timeout_err = timeout_err_q;

endmodule
`default_nettype wire
